pwm_sample_player: RTL and testbench
====================================

// Module: pwm_sample_player
// PURPOSE
//  Consumer end of the combiner->PWM sample interface. Captures each 8-bit combined sample offered
//  with a one-cycle ready strobe and double-buffers it. Applies it as the duty cycle of a free-running
//  PWM frame, swapping only at frame boundaries so no frame is ever glitched. Drives the speaker pin.
// PARAMETERS
//  WIDTH     8   sample / duty / frame-counter width; frame length = 2**WIDTH ticks
//  PRESCALE  1   clk cycles per PWM tick (>=1); 1 = counter advances every clk
// PORTS
//  clk           in   1      system clock (single clock domain)
//  n_rst         in   1      synchronous active-low reset, sampled on rising clk
//  en            in   1      1 = play; 0 = return to IDLE (pwm low, buffers cleared)
//  ready         in   1      sample-valid strobe from combiner; sample taken in any cycle it is 1
//  comb_waveform in   WIDTH  unsigned sample, valid only while ready=1
//  pwm           out  1      PWM output
//  period_start  out  1      1-clk pulse on first clk of every frame
//  sample_taken  out  1      registered 1-clk ack, high the cycle after a sample is captured
//  overrun       out  1      sticky: a pending sample was overwritten before use
// BEHAVIOUR
//  Reset (n_rst=0 at clk edge): state=IDLE, cnt=0, pre=0, active=0, pending=0, pend_v=0;
//   outputs pwm=0, period_start=0, sample_taken=0, overrun=0. Reset mid-frame aborts the frame at once.
//  tick = (pre==PRESCALE-1); pre counts 0..PRESCALE-1 and wraps, only in RUN; 0 elsewhere.
//  wrap = RUN && tick && cnt==2**WIDTH-1 (cnt rolls to 0 next cycle).
//  FSM states: IDLE, RUN.
//   IDLE: cnt=0, pre=0, pwm=0. ready&&en -> active<=sample, pend_v<=0, go RUN (frame starts next cycle).
//   RUN : cnt += tick (mod 2**WIDTH). en=0 -> IDLE next cycle, pend_v<=0, active<=0; overrun kept.
//  Buffering in RUN:
//   ready && !wrap -> pending<=sample, pend_v<=1; if pend_v already 1 -> overrun<=1 (newest wins).
//   wrap && ready  -> active<=sample directly (bypass), pend_v<=0, no overrun.
//   wrap && !ready && pend_v -> active<=pending, pend_v<=0.
//   wrap && !ready && !pend_v -> active unchanged (last sample repeats).
//  sample_taken <= (ready && en) in IDLE or RUN; never for samples dropped while en=0.
//  pwm = (state==RUN) && (cnt < active), combinational from registers: duty 0 -> always low;
//   duty 2**WIDTH-1 -> high 255 of 256 ticks (WIDTH=8); never high for a full frame.
//  period_start = (state==RUN) && cnt==0 && pre==0.
//  Latency: ready in IDLE at cycle N -> RUN, period_start=1, pwm reflects sample at N+1.
//   ready in RUN -> takes effect on first clk of next frame (cnt==0).
//  overrun clears only on reset.
//  Widths: cnt, active, pending are WIDTH bits; unsigned compare; no arithmetic overflow beyond
//   cnt wrap.
// TESTING
//  1 reset: hold n_rst=0 3 clks with ready=1,en=1 -> all outputs 0, state IDLE; release -> no
//    capture until next ready.
//  2 first sample: WIDTH=8,PRESCALE=1, ready=1 sample=64 in IDLE -> next clk period_start=1;
//    pwm high exactly 64 clks of each 256-clk frame.
//  3 frame-aligned swap: playing 64, sample=192 at cnt=100 -> current frame keeps 64 high clks;
//    next frame 192; sample_taken one pulse.
//  4 overrun/bypass: two readys (10, then 20) within one frame -> next frame duty 20, overrun=1;
//    ready=1 sample=30 on wrap cycle -> next frame duty 30, overrun unchanged.
//  5 extremes + prescale: PRESCALE=4, duty 0 -> pwm never high;
//    duty 255 -> low only during last 4 clks of 1024-clk frame.
//  6 en drop mid-frame: en=0 at cnt=50 -> next clk pwm=0, IDLE; ready ignored (no sample_taken)
//    while en=0; re-enable + ready -> fresh frame from cnt=0.

Source files
------------

// File: rtl/pwm_sample_player.sv
// pwm_sample_player: captures strobed samples, double-buffers them and plays
// each one as the duty cycle of a free-running PWM frame of 2**WIDTH ticks.
// A new duty is applied only on a frame boundary, so frames are never glitched.
module pwm_sample_player #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic             ready,
  input  logic [WIDTH-1:0] comb_waveform,
  output logic             pwm,
  output logic             period_start,
  output logic             sample_taken,
  output logic             overrun
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [PW-1:0]    pre;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] pending;
  logic             pend_v;

  logic tick;
  logic wrap;

  // Tick marks the last prescaler cycle; wrap marks the last clk of a frame.
  always_comb begin
    tick = (pre == PW'(PRESCALE - 1));
    wrap = (state == RUN) && tick && (cnt == '1);
  end

  // Frame counter, prescaler, sample buffering and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pre          <= '0;
      active       <= '0;
      pending      <= '0;
      pend_v       <= 1'b0;
      sample_taken <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_taken <= ready && en;
      case (state)
        IDLE: begin
          cnt <= '0;
          pre <= '0;
          if (ready && en) begin
            active <= comb_waveform;
            pend_v <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (!en) begin
            state  <= IDLE;
            cnt    <= '0;
            pre    <= '0;
            pend_v <= 1'b0;
            active <= '0;
          end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) cnt <= cnt + 1'b1;
            // On the wrap cycle a fresh strobe bypasses the pending slot;
            // otherwise the pending sample (if any) becomes the next duty.
            if (wrap) begin
              if (ready)       active <= comb_waveform;
              else if (pend_v) active <= pending;
              pend_v <= 1'b0;
            end else if (ready) begin
              pending <= comb_waveform;
              pend_v  <= 1'b1;
              if (pend_v) overrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded directly from registered state.
  always_comb begin
    pwm          = (state == RUN) && (cnt < active);
    period_start = (state == RUN) && (cnt == '0) && (pre == '0);
  end

endmodule

// File: tb/tb_pwm_sample_player.sv
// Directed bench for pwm_sample_player: one instance at PRESCALE=1 for the
// buffering/swap behaviour and one at PRESCALE=4 for duty extremes.
module tb_pwm_sample_player;

  logic       clk;
  logic       n_rst;
  logic       en8, ready8;
  logic [7:0] sample8;
  logic       pwm8, ps8, st8, ovr8;
  logic       en4, ready4;
  logic [7:0] sample4;
  logic       pwm4, ps4, st4, ovr4;

  int n_checks;
  int n_fail;
  int h, h2, t, s;

  pwm_sample_player #(.WIDTH(8), .PRESCALE(1)) dut8 (
    .clk(clk), .n_rst(n_rst), .en(en8), .ready(ready8), .comb_waveform(sample8),
    .pwm(pwm8), .period_start(ps8), .sample_taken(st8), .overrun(ovr8)
  );

  pwm_sample_player #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .en(en4), .ready(ready4), .comb_waveform(sample4),
    .pwm(pwm4), .period_start(ps4), .sample_taken(st4), .overrun(ovr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples n consecutive negedges of the selected instance, counting pwm-high,
  // sample_taken and period_start cycles. Any ready strobe set before the call
  // lasts exactly one rising edge.
  task automatic run_frame(input bit sel4, input int n,
                           output int highs, output int takes, output int starts);
    highs = 0; takes = 0; starts = 0;
    for (int i = 0; i < n; i++) begin
      if (sel4) begin
        highs += int'(pwm4); takes += int'(st4); starts += int'(ps4);
      end else begin
        highs += int'(pwm8); takes += int'(st8); starts += int'(ps8);
      end
      @(negedge clk);
      ready8 = 1'b0;
      ready4 = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_rst = 1'b0;
    en8 = 1'b1; ready8 = 1'b1; sample8 = 8'd77;
    en4 = 1'b1; ready4 = 1'b1; sample4 = 8'd77;

    // 1: reset held with ready/en asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_pwm", pwm8, 0);
      check("rst_ps", ps8, 0);
      check("rst_st", st8, 0);
      check("rst_ovr", ovr8, 0);
    end
    check("rst_pwm4", pwm4, 0);
    ready8 = 1'b0; ready4 = 1'b0; en8 = 1'b0; en4 = 1'b0;
    n_rst = 1'b1;
    run_frame(1'b0, 4, h, t, s);
    check("post_rst_idle_pwm", h, 0);
    check("post_rst_idle_takes", t, 0);
    check("post_rst_idle_starts", s, 0);

    // 5: PRESCALE=4 extremes, duty 0 then 255
    en4 = 1'b1; ready4 = 1'b1; sample4 = 8'd0;
    @(negedge clk);
    ready4 = 1'b0;
    check("p4_first_ps", ps4, 1);
    check("p4_first_st", st4, 1);
    ready4 = 1'b1; sample4 = 8'd255;
    run_frame(1'b1, 1024, h, t, s);
    check("p4_duty0_highs", h, 0);
    check("p4_duty0_starts", s, 1);
    run_frame(1'b1, 1020, h, t, s);
    check("p4_duty255_highs", h, 1020);
    check("p4_duty255_starts", s, 1);
    run_frame(1'b1, 4, h, t, s);
    check("p4_duty255_tail", h, 0);
    check("p4_ps_next", ps4, 1);
    en4 = 1'b0;

    // 2: first sample from IDLE
    en8 = 1'b1; ready8 = 1'b1; sample8 = 8'd64;
    @(negedge clk);
    ready8 = 1'b0;
    check("first_ps", ps8, 1);
    check("first_pwm", pwm8, 1);
    check("first_st", st8, 1);
    check("p4_idle_pwm", pwm4, 0);
    run_frame(1'b0, 256, h, t, s);
    check("f1_highs", h, 64);
    check("f1_starts", s, 1);

    // 3: mid-frame update waits for the frame boundary
    run_frame(1'b0, 100, h, t, s);
    ready8 = 1'b1; sample8 = 8'd192;
    run_frame(1'b0, 156, h2, t, s);
    check("f2_highs", h + h2, 64);
    check("f2_takes", t, 1);
    check("f2_overrun", ovr8, 0);
    run_frame(1'b0, 256, h, t, s);
    check("f3_highs", h, 192);
    check("f3_takes", t, 0);
    check("f3_starts", s, 1);

    // 4: overrun (newest wins), then bypass on the wrap cycle
    run_frame(1'b0, 10, h, t, s);
    ready8 = 1'b1; sample8 = 8'd10;
    run_frame(1'b0, 10, h2, t, s);
    h += h2;
    check("ovr_after_one", ovr8, 0);
    ready8 = 1'b1; sample8 = 8'd20;
    run_frame(1'b0, 236, h2, t, s);
    check("f4_highs", h + h2, 192);
    check("ovr_after_two", ovr8, 1);
    run_frame(1'b0, 256, h, t, s);
    check("f5_highs", h, 20);
    run_frame(1'b0, 255, h, t, s);
    ready8 = 1'b1; sample8 = 8'd30;
    run_frame(1'b0, 1, h2, t, s);
    check("f6_highs", h + h2, 20);
    run_frame(1'b0, 256, h, t, s);
    check("f7_bypass_highs", h, 30);
    check("f7_takes", t, 1);
    check("f7_overrun", ovr8, 1);
    run_frame(1'b0, 256, h, t, s);
    check("f8_repeat_highs", h, 30);

    // 6: enable drop mid-frame, ignored strobe, re-enable
    run_frame(1'b0, 128, h, t, s);
    ready8 = 1'b1; sample8 = 8'd200;
    run_frame(1'b0, 128, h, t, s);
    run_frame(1'b0, 50, h, t, s);
    check("pre_drop_pwm", pwm8, 1);
    en8 = 1'b0;
    @(negedge clk);
    check("drop_pwm", pwm8, 0);
    check("drop_ps", ps8, 0);
    check("drop_ovr_kept", ovr8, 1);
    ready8 = 1'b1; sample8 = 8'd5;
    run_frame(1'b0, 5, h, t, s);
    check("dis_highs", h, 0);
    check("dis_takes", t, 0);
    check("dis_starts", s, 0);
    en8 = 1'b1; ready8 = 1'b1; sample8 = 8'd100;
    @(negedge clk);
    ready8 = 1'b0;
    check("reen_ps", ps8, 1);
    check("reen_pwm", pwm8, 1);
    run_frame(1'b0, 256, h, t, s);
    check("reen_highs", h, 100);
    check("reen_takes", t, 1);
    check("reen_starts", s, 1);

    // Reset mid-frame aborts at once and clears overrun
    run_frame(1'b0, 20, h, t, s);
    n_rst = 1'b0;
    @(negedge clk);
    check("midrst_pwm", pwm8, 0);
    check("midrst_ovr", ovr8, 0);
    check("midrst_ps", ps8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
